// File: rtl/cpu_oci_trace_capture_if.sv
// Bundles the DCT capture inputs, control strobes and read-out port of the trace collector.
// master drives the strobes and rd_ready; slave is the collector.
interface cpu_oci_trace_capture_if #(
  parameter int DCT_W   = 30,
  parameter int CNT_W   = 4,
  parameter int DEPTH   = 16,
  parameter int RDCNT_W = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                   dct_valid;
  logic [DCT_W-1:0]       dct_buffer;
  logic [CNT_W-1:0]       dct_count;
  logic                   wrap_mode;
  logic                   test_ending;
  logic                   test_has_ended;
  logic                   rd_ready;
  logic                   rd_valid;
  logic [CNT_W+DCT_W-1:0] rd_data;
  logic [ADDR_W:0]        level;
  logic                   overflow;
  logic [RDCNT_W-1:0]     rd_total;
  logic                   done;

  modport master (
    output dct_valid, dct_buffer, dct_count, wrap_mode,
    output test_ending, test_has_ended, rd_ready,
    input  rd_valid, rd_data, level, overflow, rd_total, done
  );

  modport slave (
    input  dct_valid, dct_buffer, dct_count, wrap_mode,
    input  test_ending, test_has_ended, rd_ready,
    output rd_valid, rd_data, level, overflow, rd_total, done
  );
endinterface

// File: rtl/cpu_oci_trace_capture.sv
// DCT trace collector: circular frame buffer with first-word fall-through read-out,
// wrap/drop policy on full, and a CAPTURE -> DRAIN -> DONE sequencer.
module cpu_oci_trace_capture #(
  parameter int DCT_W   = 30,
  parameter int CNT_W   = 4,
  parameter int DEPTH   = 16,
  parameter int RDCNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  cpu_oci_trace_capture_if.slave  bus
);
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int FRAME_W = CNT_W + DCT_W;
  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [FRAME_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]    level_reg;
  logic               overflow_reg;
  logic [RDCNT_W-1:0] rd_total_reg;

  logic full, empty, rd_valid_int, pop, wr_req, wr_en, evict, drop, level_inc;

  always_comb begin
    full         = (level_reg == FULL_LEVEL);
    empty        = (level_reg == '0);
    rd_valid_int = !empty && (state_reg != ST_DONE);
    pop          = rd_valid_int && bus.rd_ready;
    wr_req       = bus.dct_valid && (state_reg == ST_CAPTURE);
    // On full without a pop, wrap mode sacrifices the oldest frame; otherwise the new one is lost.
    drop         = wr_req && full && !pop;
    evict        = drop && bus.wrap_mode;
    wr_en        = wr_req && (!full || pop || bus.wrap_mode);
    level_inc    = wr_en && !evict;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CAPTURE: begin
        if (bus.test_has_ended)   state_next = ST_DONE;
        else if (bus.test_ending) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.test_has_ended || empty) state_next = ST_DONE;
      end
      default: state_next = ST_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= {bus.dct_count, bus.dct_buffer};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_CAPTURE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
      rd_total_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (wr_en)        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop || evict) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (level_inc && !pop)      level_reg <= level_reg + 1'b1;
      else if (!level_inc && pop) level_reg <= level_reg - 1'b1;
      if (drop) overflow_reg <= 1'b1;
      if (pop)  rd_total_reg <= rd_total_reg + 1'b1;
    end
  end

  always_comb begin
    bus.rd_valid = rd_valid_int;
    bus.rd_data  = rd_valid_int ? mem[rd_ptr_reg] : '0;
    bus.level    = level_reg;
    bus.overflow = overflow_reg;
    bus.rd_total = rd_total_reg;
    bus.done     = (state_reg == ST_DONE);
  end
endmodule

// File: tb/tb_cpu_oci_trace_capture.sv
// Scoreboard bench for the DCT trace collector: a queue model predicts every read-out frame
// and the status outputs, each scenario task adds its own targeted checks.
module tb_cpu_oci_trace_capture;
  localparam int DCT_W   = 30;
  localparam int CNT_W   = 4;
  localparam int DEPTH   = 16;
  localparam int RDCNT_W = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cpu_oci_trace_capture_if #(.DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .RDCNT_W(RDCNT_W)) bus ();

  cpu_oci_trace_capture #(.DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .RDCNT_W(RDCNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [CNT_W+DCT_W-1:0] q[$];
  int mstate;              // 0 capture, 1 drain, 2 done
  logic movf;
  logic [RDCNT_W-1:0] mtotal;
  int npops;

  task automatic model_clear();
    q.delete();
    mstate = 0;
    movf   = 1'b0;
    mtotal = '0;
    npops  = 0;
  endtask

  task automatic drive_idle();
    bus.dct_valid      = 1'b0;
    bus.dct_buffer     = '0;
    bus.dct_count      = '0;
    bus.test_ending    = 1'b0;
    bus.test_has_ended = 1'b0;
    bus.rd_ready       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive_idle();
    bus.wrap_mode = 1'b0;
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One clock of stimulus: compare current outputs against the model, then advance the model.
  task automatic cycle(input logic v, input logic [DCT_W-1:0] b, input logic [CNT_W-1:0] c,
                       input logic rdy, input logic te, input logic th);
    logic mvalid, mpop, mfull, mempty;
    logic [CNT_W+DCT_W-1:0] exp_data;
    @(negedge clk);
    bus.dct_valid      = v;
    bus.dct_buffer     = b;
    bus.dct_count      = c;
    bus.rd_ready       = rdy;
    bus.test_ending    = te;
    bus.test_has_ended = th;
    mempty   = (q.size() == 0);
    mvalid   = !mempty && (mstate != 2);
    exp_data = mvalid ? q[0] : '0;
    checks++;
    if (bus.rd_valid !== mvalid) begin
      errors++; $display("FAIL rd_valid actual=%b expected=%b", bus.rd_valid, mvalid);
    end
    checks++;
    if (bus.rd_data !== exp_data) begin
      errors++; $display("FAIL rd_data actual=%h expected=%h", bus.rd_data, exp_data);
    end
    checks++;
    if (bus.level !== 5'(q.size())) begin
      errors++; $display("FAIL level actual=%0d expected=%0d", bus.level, q.size());
    end
    checks++;
    if (bus.overflow !== movf) begin
      errors++; $display("FAIL overflow actual=%b expected=%b", bus.overflow, movf);
    end
    checks++;
    if (bus.done !== (mstate == 2)) begin
      errors++; $display("FAIL done actual=%b expected=%b", bus.done, (mstate == 2));
    end
    checks++;
    if (bus.rd_total !== mtotal) begin
      errors++; $display("FAIL rd_total actual=%0d expected=%0d", bus.rd_total, mtotal);
    end
    mpop  = mvalid && rdy;
    mfull = (q.size() == DEPTH);
    if (mpop) begin
      $display("pop frame=%h total=%0d", q[0], mtotal + 1'b1);
      void'(q.pop_front());
      mtotal++;
      npops++;
    end
    if (v && mstate == 0) begin
      if (mfull && !mpop) begin
        movf = 1'b1;
        if (bus.wrap_mode) begin
          void'(q.pop_front());
          q.push_back({c, b});
        end
      end else begin
        q.push_back({c, b});
      end
    end
    if (th) mstate = 2;
    else if (mstate == 0 && te) mstate = 1;
    else if (mstate == 1 && mempty) mstate = 2;
  endtask

  task automatic drain_all();
    for (int i = 0; i < 4 * DEPTH && q.size() != 0; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    if (q.size() != 0) begin
      errors++; $display("FAIL drain_timeout remaining=%0d expected=0", q.size());
    end
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive_idle();
    bus.wrap_mode = 1'b0;
    model_clear();
    #1;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL reset_flags actual=%b%b%b expected=000", bus.rd_valid, bus.done, bus.overflow);
    end
    checks++;
    if (bus.level !== '0 || bus.rd_total !== '0 || bus.rd_data !== '0) begin
      errors++; $display("FAIL reset_values level=%0d total=%0d data=%h expected=0", bus.level, bus.rd_total, bus.rd_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 3; i++) cycle(1'b1, DCT_W'(i), 4'h1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.level !== 5'd3) begin errors++; $display("FAIL basic_level actual=%0d expected=3", bus.level); end
    checks++;
    if (bus.rd_data !== {4'h1, 30'h1}) begin errors++; $display("FAIL basic_data actual=%h expected=%h", bus.rd_data, {4'h1, 30'h1}); end
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow actual=%b expected=0", bus.overflow); end
    drain_all();
  endtask

  task automatic test_fill20(input logic wrap, input logic [DCT_W-1:0] first_exp);
    do_reset();
    bus.wrap_mode = wrap;
    for (int i = 0; i < 20; i++) cycle(1'b1, DCT_W'(i), 4'h2, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.level !== 5'd16 || bus.overflow !== 1'b1) begin
      errors++; $display("FAIL fill20_wrap%0b level=%0d ovf=%b expected 16/1", wrap, bus.level, bus.overflow);
    end
    checks++;
    if (bus.rd_data !== {4'h2, first_exp}) begin
      errors++; $display("FAIL fill20_head_wrap%0b actual=%h expected=%h", wrap, bus.rd_data, {4'h2, first_exp});
    end
    drain_all();
    checks++;
    if (bus.rd_total !== 16'd16) begin errors++; $display("FAIL fill20_total actual=%0d expected=16", bus.rd_total); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DCT_W'(100 + i), 4'h3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, DCT_W'(200 + i), 4'h4, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.level !== 5'd16 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL b2b level=%0d ovf=%b expected 16/0", bus.level, bus.overflow);
    end
    checks++;
    if (bus.rd_data !== {4'h3, 30'd105}) begin
      errors++; $display("FAIL b2b_head actual=%h expected=%h", bus.rd_data, {4'h3, 30'd105});
    end
    drain_all();
  endtask

  task automatic test_drain();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, DCT_W'(50 + i), 4'h5, 1'b0, 1'b0, 1'b0);
    npops = 0;
    cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (npops != 5 || bus.done !== 1'b1) begin
      errors++; $display("FAIL drain pops=%0d done=%b expected 5/1", npops, bus.done);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, DCT_W'(77), 4'h6, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.level !== '0) begin errors++; $display("FAIL drain_ignore level=%0d expected=0", bus.level); end
  endtask

  task automatic test_abort();
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, DCT_W'(300 + i), 4'h7, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, DCT_W'(9), 4'h7, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.done !== 1'b1 || bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL abort done=%b rd_valid=%b expected 1/0", bus.done, bus.rd_valid);
    end
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.level !== 5'd8) begin errors++; $display("FAIL abort_frozen level=%0d expected=8", bus.level); end
    do_reset();
    bus.wrap_mode = 1'b0;
    for (int i = 0; i < 8; i++) cycle(1'b1, DCT_W'(400 + i), 4'h8, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.level !== '0 || bus.rd_total !== '0 || bus.rd_data !== '0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL midreset valid=%b level=%0d total=%0d data=%h done=%b expected all 0",
                         bus.rd_valid, bus.level, bus.rd_total, bus.rd_data, bus.done);
    end
    drive_idle();
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    drive_idle();
    bus.wrap_mode = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_fill20(1'b0, 30'd0);
    test_fill20(1'b1, 30'd4);
    test_back_to_back();
    test_drain();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
